// File: rtl/store_issue_ctrl.sv
// Store buffer and two-phase bus issue for the data-side SRAM-like port.
// Optional STQ_ALE_CHECK_EN: flag and drop misaligned stores (adds in_ale).
module store_issue_ctrl #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_data,
`ifdef STQ_ALE_CHECK_EN
  output logic        in_ale,
`endif
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MAXO_P  = PW'(MAX_OUTSTANDING);

  logic [PW-1:0] head_q, iss_q, tail_q;
  logic [PW-1:0] head_d, iss_d, tail_d;
  logic [PW-1:0] count, outst;

  logic [31:0] addr_q  [DEPTH];
  logic [1:0]  size_q  [DEPTH];
  logic [3:0]  wstrb_q [DEPTH];
  logic [31:0] wdata_q [DEPTH];

  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic        enq, iss_go, ret;

  assign count    = tail_q - head_q;
  assign outst    = iss_q - head_q;
  assign in_ready = count < DEPTH_P;
  assign empty    = count == '0;

`ifdef STQ_ALE_CHECK_EN
  assign in_ale = in_valid &&
                  ((in_size == 2'd1 && in_addr[0]) ||
                   (in_size == 2'd2 && in_addr[1:0] != 2'd0) ||
                   in_size == 2'd3);
  assign enq = in_valid && in_ready && !in_ale;
`else
  assign enq = in_valid && in_ready;
`endif

  // Lane placement; size 3 leaves strobe and data zero.
  always_comb begin
    wstrb_n = 4'b0000;
    wdata_n = 32'h0;
    case (in_size)
      2'd0: begin
        wstrb_n = 4'b0001 << in_addr[1:0];
        wdata_n = {24'h0, in_data[7:0]} << {in_addr[1:0], 3'b000};
      end
      2'd1: begin
        wstrb_n = in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = in_addr[1] ? {in_data[15:0], 16'h0}
                             : {16'h0, in_data[15:0]};
      end
      2'd2: begin
        wstrb_n = 4'b1111;
        wdata_n = in_data;
      end
      default: ;
    endcase
  end

  assign data_req   = (iss_q != tail_q) && (outst < MAXO_P);
  assign data_wr    = 1'b1;
  assign data_addr  = addr_q[iss_q[AW-1:0]];
  assign data_size  = size_q[iss_q[AW-1:0]];
  assign data_wstrb = wstrb_q[iss_q[AW-1:0]];
  assign data_wdata = wdata_q[iss_q[AW-1:0]];

  assign iss_go = data_req && data_addr_ok;
  assign ret    = data_data_ok && (outst != '0);

  assign head_d = ret    ? head_q + 1'b1 : head_q;
  assign iss_d  = iss_go ? iss_q + 1'b1  : iss_q;
  assign tail_d = enq    ? tail_q + 1'b1 : tail_q;

  // Every held entry counts, issued or not.
  always_comb begin
    ld_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < count &&
          addr_q[AW'(head_q + PW'(k))][31:2] == ld_addr[31:2] &&
          wstrb_q[AW'(head_q + PW'(k))] != 4'b0000)
        ld_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      iss_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      iss_q  <= iss_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q[AW-1:0]]  <= in_addr;
      size_q[tail_q[AW-1:0]]  <= in_size;
      wstrb_q[tail_q[AW-1:0]] <= wstrb_n;
      wdata_q[tail_q[AW-1:0]] <= wdata_n;
    end
  end

endmodule

// File: tb/tb_store_issue_ctrl.sv
// Directed bench for store_issue_ctrl (DEPTH 4, MAX_OUTSTANDING 2).
// Inputs change 1ns after the rising edge; outputs sampled 2ns after.
module tb_store_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic [31:0] in_data;
`ifdef STQ_ALE_CHECK_EN
  logic        in_ale;
`endif
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_issue_ctrl #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_size      (in_size),
    .in_data      (in_data),
`ifdef STQ_ALE_CHECK_EN
    .in_ale       (in_ale),
`endif
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .empty        (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 0; in_addr = 0; in_size = 0; in_data = 0;
    data_addr_ok = 0; data_data_ok = 0; ld_addr = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL rst_req got %b want 0", data_req); end
    checks++; if (ld_hit !== 1'b0) begin errors++;
      $display("FAIL rst_hit got %b want 0", ld_hit); end
    checks++; if (empty !== 1'b1) begin errors++;
      $display("FAIL rst_empty got %b want 1", empty); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %b want 1", in_ready); end
    checks++; if (data_wr !== 1'b1) begin errors++;
      $display("FAIL rst_wr got %b want 1", data_wr); end
  endtask

  task automatic test_byte();
    in_valid = 1; in_addr = 32'h1003; in_size = 0; in_data = 32'hAB;
    data_addr_ok = 1;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL byte_req_early got %b want 0", data_req); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++;
      $display("FAIL byte_req got %b want 1", data_req); end
    checks++; if (data_wstrb !== 4'b1000) begin errors++;
      $display("FAIL byte_strb got %b want 1000", data_wstrb); end
    checks++; if (data_wdata !== 32'hAB000000) begin errors++;
      $display("FAIL byte_wdata got %h want ab000000", data_wdata); end
    checks++; if (data_addr !== 32'h1003) begin errors++;
      $display("FAIL byte_addr got %h want 00001003", data_addr); end
    checks++; if (data_size !== 2'd0) begin errors++;
      $display("FAIL byte_size got %0d want 0", data_size); end
    tick();
    data_addr_ok = 0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL byte_req_after got %b want 0", data_req); end
    checks++; if (empty !== 1'b0) begin errors++;
      $display("FAIL byte_not_empty got %b want 0", empty); end
    tick();
    data_data_ok = 1;
    tick();
    data_data_ok = 0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++;
      $display("FAIL byte_empty got %b want 1", empty); end
  endtask

  task automatic test_fill();
    data_addr_ok = 0; data_data_ok = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_size = 2;
      in_addr = 32'h100 + 4 * i; in_data = 32'hA0000000 + i;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL fill_ready%0d got %b want 1", i, in_ready); end
      tick();
    end
    in_addr = 32'h110; in_data = 32'hA0000004;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL fill_full got %b want 0", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL fill_held got %b want 0", in_ready); end
    checks++; if (data_addr !== 32'h100) begin errors++;
      $display("FAIL fill_stall_addr got %h want 00000100", data_addr); end
    tick();
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h100 ||
                  data_wdata !== 32'hA0000000) begin errors++;
      $display("FAIL fill_stable req %b addr %h data %h want 1 100 a0000000",
               data_req, data_addr, data_wdata); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (data_req !== 1'b1 || data_addr !== 32'h100 + 4 * i ||
                    data_wdata !== 32'hA0000000 + i) begin errors++;
        $display("FAIL fill_order%0d req %b addr %h data %h", i,
                 data_req, data_addr, data_wdata); end
      data_addr_ok = 1; data_data_ok = (i > 0);
      tick();
    end
    data_addr_ok = 0; data_data_ok = 1;
    tick();
    data_data_ok = 0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++;
      $display("FAIL fill_drain got %b want 1", empty); end
  endtask

  task automatic test_outstanding();
    data_addr_ok = 1; data_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_size = 2;
      in_addr = 32'h200 + 4 * i; in_data = i;
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL ost_limit got %b want 0", data_req); end
    tick();
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL ost_limit2 got %b want 0", data_req); end
    data_data_ok = 1;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL ost_same_cycle got %b want 0", data_req); end
    tick();
    data_data_ok = 0;
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h208) begin errors++;
      $display("FAIL ost_third req %b addr %h want 1 00000208",
               data_req, data_addr); end
    tick();
    #1;
    checks++; if (data_req !== 1'b0) begin errors++;
      $display("FAIL ost_done got %b want 0", data_req); end
    data_addr_ok = 0; data_data_ok = 1;
    tick(); tick();
    data_data_ok = 0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++;
      $display("FAIL ost_empty got %b want 1", empty); end
  endtask

  task automatic test_hazard();
    data_addr_ok = 0; data_data_ok = 0;
    in_valid = 1; in_addr = 32'h2002; in_size = 1; in_data = 32'hFFFF1234;
    tick();
    in_valid = 0; ld_addr = 32'h2000;
    #1;
    checks++; if (ld_hit !== 1'b1) begin errors++;
      $display("FAIL hz_hit got %b want 1", ld_hit); end
    checks++; if (data_wstrb !== 4'b1100 || data_wdata !== 32'h12340000)
      begin errors++;
      $display("FAIL hz_half strb %b data %h want 1100 12340000",
               data_wstrb, data_wdata); end
    ld_addr = 32'h2004;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++;
      $display("FAIL hz_other got %b want 0", ld_hit); end
    ld_addr = 32'h2003; data_addr_ok = 1;
    tick();
    data_addr_ok = 0;
    #1;
    checks++; if (ld_hit !== 1'b1) begin errors++;
      $display("FAIL hz_issued got %b want 1", ld_hit); end
    data_data_ok = 1;
    tick();
    data_data_ok = 0;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++;
      $display("FAIL hz_retired got %b want 0", ld_hit); end
    in_valid = 1; in_addr = 32'h2000; in_size = 3; in_data = 32'hFFFFFFFF;
    tick();
    in_valid = 0;
    #1;
    checks++; if (empty !== 1'b0 || ld_hit !== 1'b0) begin errors++;
      $display("FAIL hz_size3 empty %b hit %b want 0 0", empty, ld_hit); end
    checks++; if (data_wstrb !== 4'b0000 || data_wdata !== 32'h0)
      begin errors++;
      $display("FAIL hz_size3_lane strb %b data %h want 0000 0",
               data_wstrb, data_wdata); end
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1;
    tick();
    data_data_ok = 0;
  endtask

  task automatic test_lanes();
    logic [31:0] va [3] = '{32'h2001, 32'h2000, 32'h3002};
    logic [1:0]  vs [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] vd [3] = '{32'h123456CD, 32'hFFFF5678, 32'hDEADBEEF};
    logic [3:0]  es [3] = '{4'b0010, 4'b0011, 4'b1111};
    logic [31:0] ed [3] = '{32'h0000CD00, 32'h00005678, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_addr = va[i]; in_size = vs[i]; in_data = vd[i];
`ifdef STQ_ALE_CHECK_EN
      #1;
      checks++; if (in_ale !== (i == 2)) begin errors++;
        $display("FAIL lane_ale%0d got %b want %b", i, in_ale, i == 2); end
`endif
      tick();
      in_valid = 0;
      #1;
`ifdef STQ_ALE_CHECK_EN
      if (i == 2) begin
        checks++; if (empty !== 1'b1) begin errors++;
          $display("FAIL lane_ale_drop got %b want 1", empty); end
        continue;
      end
`endif
      checks++; if (data_wstrb !== es[i] || data_wdata !== ed[i] ||
                    data_addr !== va[i]) begin errors++;
        $display("FAIL lane%0d strb %b data %h addr %h want %b %h %h", i,
                 data_wstrb, data_wdata, data_addr, es[i], ed[i], va[i]); end
      data_addr_ok = 1;
      tick();
      data_addr_ok = 0; data_data_ok = 1;
      tick();
      data_data_ok = 0;
    end
  endtask

  task automatic test_simultaneous();
    data_addr_ok = 0; data_data_ok = 0;
    in_valid = 1; in_size = 2; in_addr = 32'h400; in_data = 0;
    tick();
    in_addr = 32'h404; data_addr_ok = 1;
    tick();
    in_addr = 32'h408; data_data_ok = 1;
    tick();
    in_valid = 0; data_addr_ok = 0; data_data_ok = 0;
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h408) begin errors++;
      $display("FAIL sim_iss req %b addr %h want 1 00000408",
               data_req, data_addr); end
    checks++; if (in_ready !== 1'b1 || empty !== 1'b0) begin errors++;
      $display("FAIL sim_state ready %b empty %b want 1 0",
               in_ready, empty); end
    in_valid = 1; in_addr = 32'h40C;
    tick();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL sim_count3 got %b want 1", in_ready); end
    in_addr = 32'h410;
    tick();
    in_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL sim_count4 got %b want 0", in_ready); end
    resetn = 0;
    #1;
    checks++; if (empty !== 1'b1 || data_req !== 1'b0) begin errors++;
      $display("FAIL sim_rst empty %b req %b want 1 0", empty, data_req); end
    tick();
    resetn = 1; ld_addr = 32'h400;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++;
      $display("FAIL sim_rst_hit got %b want 0", ld_hit); end
    data_data_ok = 1;
    tick();
    data_data_ok = 0;
    #1;
    checks++; if (empty !== 1'b1 || data_req !== 1'b0 || in_ready !== 1'b1)
      begin errors++;
      $display("FAIL sim_stray_ok empty %b req %b ready %b want 1 0 1",
               empty, data_req, in_ready); end
    in_valid = 1; in_addr = 32'h500; in_data = 32'h55;
    tick();
    in_valid = 0;
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h500) begin errors++;
      $display("FAIL sim_after req %b addr %h want 1 00000500",
               data_req, data_addr); end
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1;
    tick();
    data_data_ok = 0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_size = 2; in_addr = 32'h600 + 4 * i; in_data = i;
      tick();
      in_valid = 0;
      #1;
      checks++; if (data_req !== 1'b1 || data_addr !== 32'h600 + 4 * i)
        begin errors++;
        $display("FAIL wrap_iss%0d req %b addr %h", i, data_req, data_addr);
      end
      data_addr_ok = 1;
      tick();
      data_addr_ok = 0; data_data_ok = 1;
      tick();
      data_data_ok = 0;
      #1;
      checks++; if (empty !== 1'b1) begin errors++;
        $display("FAIL wrap_empty%0d got %b want 1", i, empty); end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_fill();
    test_outstanding();
    test_hazard();
    test_lanes();
    test_simultaneous();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_issue_ctrl.md
# store_issue_ctrl

Store-path controller between the MEM stage and the data-side SRAM-like bus. Accepts committed stores (address, size, raw register data), generates the byte strobe and lane-aligned write data, queues them in a small in-order buffer, and issues them on the bus with an address/data two-phase handshake. It also reports load-address hazards against every store not yet acknowledged.

## Interface
- `DEPTH`, 4: buffer entries; power of two, 2..16.
- `MAX_OUTSTANDING`, 2: issued stores awaiting `data_ok`; 1..`DEPTH`.

- `clk` in 1: single clock; all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: store request valid.
- `in_ready` out 1: buffer can accept.
- `in_addr` in 32: byte address.
- `in_size` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `in_data` in 32: unaligned source data; low bits hold the value.
- `in_ale` out 1: misaligned-store flag. Present only with `STQ_ALE_CHECK_EN`.
- `data_req` out 1: bus request.
- `data_wr` out 1: constant 1.
- `data_size` out 2: size of the issued entry.
- `data_addr` out 32: address of the issued entry.
- `data_wstrb` out 4: byte strobe.
- `data_wdata` out 32: lane-aligned write data.
- `data_addr_ok` in 1: address phase accepted.
- `data_data_ok` in 1: write completed; oldest outstanding retires.
- `ld_addr` in 32: address of the load in MEM.
- `ld_hit` out 1: a buffered store overlaps `ld_addr`'s word.
- `empty` out 1: no entries held.

## Operation
- Entry fields: addr, size, wstrb, wdata. They are computed at enqueue.
- Strobe and data by size:
  - Size 0: `wstrb = 1 << addr[1:0]`; `in_data[7:0]` is placed in that byte lane.
  - Size 1: `wstrb = addr[1] ? 1100 : 0011`; `in_data[15:0]` is placed in that half.
  - Size 2: `wstrb = 1111`; data passes unchanged.
  - Size 3: `wstrb = 0000`, `wdata = 0`.
  - Unselected lanes are 0.
- Pointers `head` (retire), `iss` (next issue) and `tail` (enqueue) are each log2(`DEPTH`)+1 bits and wrap modulo 2·`DEPTH`.
  - `count = tail - head`.
  - `outstanding = iss - head`.
- Enqueue when `in_valid && in_ready`. `in_ready = count < DEPTH`, with no same-cycle credit from retire.
- Issue:
  - `data_req = (iss != tail) && (outstanding < MAX_OUTSTANDING)`.
  - Bus fields come from entry `iss`.
  - `data_req && data_addr_ok` advances `iss`.
- Retire: `data_data_ok` advances `head` when `outstanding > 0`. If `outstanding == 0`, `data_data_ok` is ignored (protocol error, no state change).
- Strict in-order: issue order and retire order are both enqueue order.
- `ld_hit`: combinational OR over entries between `head` and `tail` (issued or not) of `entry.addr[31:2] == ld_addr[31:2] && (entry.wstrb != 0)`.
- `empty = (count == 0)`.

## Timing
- Reset values: all pointers 0; `data_req` 0; `ld_hit` 0; `empty` 1; `in_ready` 1; `in_ale` 0.
- Latency:
  - Entry enqueued at edge N can drive `data_req` in cycle N+1 at the earliest.
  - Retire takes effect at the edge that samples `data_ok`.
- Request fields stay stable while `data_req` is 1 and `data_addr_ok` is 0. `data_req` never drops before `addr_ok`.
- Simultaneous events in one cycle:
  - Enqueue + retire: count unchanged.
  - `addr_ok` + `data_ok`: `iss` and `head` both advance; the `data_ok` belongs to an older entry.
  - Enqueue + issue + retire together are legal.
- Full: with `count == DEPTH`, `in_ready` is 0 even if `data_ok` is high that cycle.
- `outstanding == MAX_OUTSTANDING`: `data_req` is 0 until a `data_ok`. It may re-assert in the cycle after that retire edge.
- Pointer wrap: `DEPTH` entries cycled repeatedly keep `count` correct.
- Reset mid-operation: all entries are discarded immediately. Any later `data_ok` is ignored by the `outstanding == 0` rule.

## Configuration
- `STQ_ALE_CHECK_EN` defined:
  - `in_ale = in_valid && ((size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || size==3)`. It is combinational and independent of `in_ready`.
  - Requests with `in_ale` set are never enqueued; `in_ready` is unaffected.
- Undefined:
  - The `in_ale` port is absent.
  - Misaligned requests are enqueued, and the address low bits are used unchanged for the strobe.
  - Size 3 is enqueued with `wstrb = 0000`.

## Test plan
- Byte store: addr 0x1003, data 0x000000AB, `addr_ok` immediate -> `data_req` in cycle after enqueue, `wstrb` 1000, `wdata` 0xAB000000. `data_ok` 2 cycles later -> `empty` 1.
- Fill: 5 back-to-back stores with `addr_ok` held 0, `DEPTH` 4 -> `in_ready` falls after 4th enqueue, 5th held. Release -> order preserved on bus, all fields stable while stalled.
- Outstanding limit: `addr_ok` always 1, `data_ok` held 0 -> exactly 2 requests issued, `data_req` 0. One `data_ok` -> third issues next cycle.
- Hazard: half store to 0x2002 buffered, `ld_addr` 0x2000 -> `ld_hit` 1. `ld_addr` 0x2004 -> 0. After retire -> 0.
- Simultaneous: enqueue, `addr_ok` and `data_ok` in the same cycle with count 2 -> count stays 2, `iss` and `head` advance. Then reset mid-stream -> `empty` 1, a later `data_ok` is ignored.
- With `STQ_ALE_CHECK_EN`: word store to 0x3002 -> `in_ale` 1, no enqueue. Without it -> enqueued with `wstrb` 1111, `data_addr` 0x3002.
